// File: rtl/md_unit_if.sv
// Request/result bundle between the E-stage issue logic and the multiply/divide unit.
// The cancel wire exists only when MDU_CANCEL_EN is defined.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
`ifdef MDU_CANCEL_EN
  logic        cancel;

  modport master (output start, md_op, A, B, cancel, input busy, HI, LO);
  modport slave  (input start, md_op, A, B, cancel, output busy, HI, LO);
`else
  modport master (output start, md_op, A, B, input busy, HI, LO);
  modport slave  (input start, md_op, A, B, output busy, HI, LO);
`endif
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit holding the architectural HI/LO registers.
// Optional flush support (cancel input) is compiled in with MDU_CANCEL_EN.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        a_p0, b_p0;
  logic [2:0]         op_p0;
  logic [31:0]        hi_q, lo_q;
  logic signed [63:0] res_p1;
  logic               busy;
  logic               cancel;
  logic               start_ok, vld_p0, vld_p1, mthi_go, mtlo_go;

  // Low 64 bits of the product are the same for signed and unsigned once
  // the operands are extended according to the signedness.
  function automatic logic signed [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                                  input logic sgn);
    logic signed [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so that
  // 0x80000000 / -1 needs no special case and truncation is toward zero.
  function automatic logic signed [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                                  input logic sgn);
    logic [31:0] ma, mb, q, r;
    logic        neg_q, neg_r;
    logic signed [63:0] res;
    neg_r = sgn & a[31];
    neg_q = sgn & (a[31] ^ b[31]);
    ma    = neg_r ? -a : a;
    mb    = (sgn & b[31]) ? -b : b;
    if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      q   = ma / mb;
      r   = ma % mb;
      res = {(neg_r ? -r : r), (neg_q ? -q : q)};
    end
    return res;
  endfunction

`ifdef MDU_CANCEL_EN
  assign cancel = bus.cancel;
`else
  assign cancel = 1'b0;
`endif

  // Stage p0: request acceptance
  assign start_ok = bus.start && (state_q == IDLE) && !cancel;
  assign vld_p0   = start_ok && (bus.md_op >= OP_MULT) && (bus.md_op <= OP_DIVU);
  assign mthi_go  = start_ok && (bus.md_op == OP_MTHI);
  assign mtlo_go  = start_ok && (bus.md_op == OP_MTLO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (vld_p0) state_d = RUN;
      RUN:  if (cancel || cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      a_p0  <= '0;
      b_p0  <= '0;
      op_p0 <= '0;
    end else if (vld_p0) begin
      cnt_q <= (bus.md_op <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      a_p0  <= bus.A;
      b_p0  <= bus.B;
      op_p0 <= bus.md_op;
    end else if (busy) begin
      cnt_q <= cancel ? '0 : cnt_q - CNT_W'(1);
    end
  end

  // Stage p1: result from latched operands, committed on the final count
  always_comb begin
    res_p1 = '0;
    case (op_p0)
      OP_MULT:  res_p1 = mul_full(a_p0, b_p0, 1'b1);
      OP_MULTU: res_p1 = mul_full(a_p0, b_p0, 1'b0);
      OP_DIV:   res_p1 = div_full(a_p0, b_p0, 1'b1);
      OP_DIVU:  res_p1 = div_full(a_p0, b_p0, 1'b0);
      default:  res_p1 = '0;
    endcase
  end

  assign vld_p1 = busy && (cnt_q == CNT_W'(1)) && !cancel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (vld_p1) begin
      hi_q <= res_p1[63:32];
      lo_q <= res_p1[31:0];
    end else begin
      if (mthi_go) hi_q <= bus.A;
      if (mtlo_go) lo_q <= bus.A;
    end
  end

  assign bus.busy = busy;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed, table-driven bench for md_unit: arithmetic vectors plus busy/mthi/reset/cancel sequences.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_unit_if mif();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        vecs[11];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi, m_lo;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int   n;
    logic ok;
    n = (vecs[i].op <= 3'd2) ? MC : DC;
    mif.start = 1'b1;
    mif.md_op = vecs[i].op;
    mif.A     = vecs[i].a;
    mif.B     = vecs[i].b;
    tick();
    mif.start = 1'b0;
    mif.md_op = 3'd0;
    ok = (mif.busy === 1'b1);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k < n) ok &= (mif.busy === 1'b1) && (mif.HI === m_hi) && (mif.LO === m_lo);
    end
    chk($sformatf("vec%0d_busy_hold", i), {31'b0, ok}, 32'd1);
    chk($sformatf("vec%0d_busy_end", i), {31'b0, mif.busy}, 32'd0);
    chk($sformatf("vec%0d_hi", i), mif.HI, vecs[i].hi);
    chk($sformatf("vec%0d_lo", i), mif.LO, vecs[i].lo);
    m_hi = vecs[i].hi;
    m_lo = vecs[i].lo;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    vecs[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'd4, 32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF};
    vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
    vecs[5]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[6]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[7]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[8]  = '{3'd3, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[9]  = '{3'd4, 32'hFFFF_FFFF, 32'd10,       32'd5,         32'h1999_9999};
    vecs[10] = '{3'd1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};

    mif.start = 1'b0;
    mif.md_op = 3'd0;
    mif.A     = '0;
    mif.B     = '0;
`ifdef MDU_CANCEL_EN
    mif.cancel = 1'b0;
`endif
    reset = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'b0, mif.busy}, 32'd0);
    chk("rst_hi", mif.HI, 32'd0);
    chk("rst_lo", mif.LO, 32'd0);
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    reset = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) run_vec(i);

    // mthi then mtlo, single cycle each
    mif.start = 1'b1; mif.md_op = 3'd5; mif.A = 32'h1234_5678;
    tick();
    chk("mthi_hi", mif.HI, 32'h1234_5678);
    chk("mthi_busy", {31'b0, mif.busy}, 32'd0);
    mif.md_op = 3'd6; mif.A = 32'h9ABC_DEF0;
    tick();
    chk("mtlo_lo", mif.LO, 32'h9ABC_DEF0);
    chk("mtlo_hi_hold", mif.HI, 32'h1234_5678);
    chk("mtlo_busy", {31'b0, mif.busy}, 32'd0);
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;

    // md_op 0 and 7 do nothing
    mif.md_op = 3'd0; mif.A = 32'hFFFF_FFFF; mif.B = 32'd3;
    tick();
    chk("op0_noeffect", {31'b0, (mif.busy === 1'b0 && mif.HI === m_hi && mif.LO === m_lo)}, 32'd1);
    mif.md_op = 3'd7;
    tick();
    chk("op7_noeffect", {31'b0, (mif.busy === 1'b0 && mif.HI === m_hi && mif.LO === m_lo)}, 32'd1);

    // mthi while busy is ignored
    mif.md_op = 3'd1; mif.A = 32'd3; mif.B = 32'd5;
    tick();
    mif.md_op = 3'd5; mif.A = 32'hDEAD_BEEF;
    tick();
    mif.start = 1'b0; mif.md_op = 3'd0;
    chk("mthi_busy_hi", mif.HI, m_hi);
    chk("mthi_busy_busy", {31'b0, mif.busy}, 32'd1);
    repeat (MC - 1) tick();
    chk("mult_after_mthi_busy", {31'b0, mif.busy}, 32'd0);
    chk("mult_after_mthi_hi", mif.HI, 32'd0);
    chk("mult_after_mthi_lo", mif.LO, 32'd15);
    m_hi = 32'd0;
    m_lo = 32'd15;

    // div 100/7 with operands toggling and a stray mult start at t+3
    mif.start = 1'b1; mif.md_op = 3'd3; mif.A = 32'd100; mif.B = 32'd7;
    tick();
    ok = (mif.busy === 1'b1);
    for (int k = 1; k <= DC; k++) begin
      mif.A     = (k % 2 != 0) ? 32'd5 : 32'hFFFF_0000;
      mif.B     = (k % 2 != 0) ? 32'd0 : 32'd3;
      mif.start = (k == 3);
      mif.md_op = (k == 3) ? 3'd1 : 3'd0;
      tick();
      if (k < DC) ok &= (mif.busy === 1'b1) && (mif.HI === m_hi) && (mif.LO === m_lo);
    end
    mif.start = 1'b0; mif.md_op = 3'd0;
    chk("robust_busy_hold", {31'b0, ok}, 32'd1);
    chk("robust_busy_end", {31'b0, mif.busy}, 32'd0);
    chk("robust_lo", mif.LO, 32'd14);
    chk("robust_hi", mif.HI, 32'd2);
    m_hi = 32'd2;
    m_lo = 32'd14;

`ifdef MDU_CANCEL_EN
    // cancel mid-run at t+9
    mif.start = 1'b1; mif.md_op = 3'd3; mif.A = 32'd50; mif.B = 32'd3;
    tick();
    mif.start = 1'b0; mif.md_op = 3'd0;
    repeat (8) tick();
    mif.cancel = 1'b1;
    tick();
    mif.cancel = 1'b0;
    chk("cancel_busy", {31'b0, mif.busy}, 32'd0);
    repeat (3) tick();
    chk("cancel_hold", {31'b0, (mif.HI === m_hi && mif.LO === m_lo && mif.busy === 1'b0)}, 32'd1);
    // cancel on the commit edge wins
    mif.start = 1'b1; mif.md_op = 3'd4; mif.A = 32'd50; mif.B = 32'd3;
    tick();
    mif.start = 1'b0; mif.md_op = 3'd0;
    repeat (DC - 1) tick();
    mif.cancel = 1'b1;
    tick();
    mif.cancel = 1'b0;
    chk("cancel_commit_edge", {31'b0, (mif.HI === m_hi && mif.LO === m_lo && mif.busy === 1'b0)}, 32'd1);
    // cancel while idle suppresses mthi
    mif.start = 1'b1; mif.md_op = 3'd5; mif.A = 32'h0000_00AA; mif.cancel = 1'b1;
    tick();
    mif.start = 1'b0; mif.md_op = 3'd0; mif.cancel = 1'b0;
    chk("cancel_idle_mthi", mif.HI, m_hi);
`endif

    // asynchronous reset mid-run discards the operation
    mif.start = 1'b1; mif.md_op = 3'd1; mif.A = 32'd3; mif.B = 32'd5;
    tick();
    mif.start = 1'b0; mif.md_op = 3'd0;
    repeat (4) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'b0, mif.busy}, 32'd0);
    chk("arst_hi", mif.HI, 32'd0);
    chk("arst_lo", mif.LO, 32'd0);
    #1;
    reset = 1'b1;
    repeat (DC) tick();
    chk("arst_no_commit", {31'b0, (mif.busy === 1'b0 && mif.HI === 32'd0 && mif.LO === 32'd0)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the pipelined MIPS core.
- Consumes the two operands read from the general register file (after forwarding) and holds the architectural HI/LO registers.
- Supplies HI/LO to the W-stage write-back mux for mfhi/mflo.
- Exports busy so the hazard unit stalls any md-class instruction in D while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, edges from accepted mult/multu start to HI/LO commit (min 1)
- DIV_CYCLES, 10, edges from accepted div/divu start to HI/LO commit (min 1)

Ports:
- clk  input  1  clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- start  input  1  request strobe, qualified by md_op
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source)
- B  input  32  operand rt (divisor / multiplier)
- busy  output  1  registered; high while an operation is pending
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- Reset (reset=0, async): busy=0, HI=0, LO=0, counter=0, operand/result latches cleared. An in-flight operation is discarded and never commits.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter active.
- Accept: on a rising edge with start=1, busy=0 and md_op in 1..4:
  - latch A, B, op; load counter with MULT_CYCLES or DIV_CYCLES; go RUN.
  - busy=1 from the following cycle.
- start while busy=1: ignored entirely; no relatch, no restart. The hazard unit guarantees this does not occur. The bench checks it is harmless.
- mthi/mtlo: with start=1, busy=0, md_op=5/6, HI/LO takes A at that edge. Single cycle, busy stays 0. Ignored while busy.
- md_op 0 or 7 with start=1: no effect.
- RUN: counter decrements each edge. At the edge where it reaches 0:
  - commit HI/LO and return to IDLE in the same edge.
  - busy falls in the same cycle HI/LO become visible.
- Total: for start sampled at edge t, HI/LO are updated and busy=0 at edge t+N (N = MULT_CYCLES or DIV_CYCLES).
- Results are computed from the latched operands. A/B changing during RUN has no effect.
- mult: signed 32x32 → 64 bits; HI = [63:32], LO = [31:0].
- multu: unsigned 32x32 → 64 bits; same HI/LO split.
- div (signed):
  - LO = quotient, truncated toward zero; HI = remainder, sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: unsigned; LO = quotient, HI = remainder.
- Divide by zero (div/divu, B=0): LO=0xFFFFFFFF, HI=A. Latency unchanged.
- HI/LO hold their value at all times other than a commit, mthi/mtlo, or reset.

Optional Feature:
- Macro MDU_CANCEL_EN.
- Defined: adds input port cancel (1 bit, after md_op).
  - cancel=1 at an edge during RUN: return to IDLE, busy=0 next cycle, HI/LO unchanged, result discarded. Used when the issuing instruction is flushed by an exception.
  - cancel in the same edge as the commit: cancel wins, no commit.
  - cancel while IDLE: suppresses any start/mthi/mtlo sampled at that same edge.
- Undefined: no cancel port; every accepted operation runs to completion.

Test Plan:
- Reset then mult A=0xFFFFFFFE (-2), B=3: busy high for 5 cycles; after edge t+5, HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- multu A=0xFFFFFFFF, B=2: HI=0x00000001, LO=0xFFFFFFFE at t+5.
- div A=0xFFFFFFF9 (-7), B=2: at t+10, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0: LO=0xFFFFFFFF, HI=7.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0: HI/LO update at each edge, busy never asserts. mthi issued while busy: HI unchanged.
- Start div A=100, B=7 with A/B toggled every cycle during RUN, plus a second start (mult) at t+3: LO=14, HI=2 at t+10, no restart.
- Assert reset=0 asynchronously mid-RUN at t+4: busy, HI and LO go 0 immediately and no commit follows. With MDU_CANCEL_EN, cancel at t+9 of a div leaves the prior HI/LO intact and busy=0.
